// File: rtl/aes_iter_core_if.sv
// Request/result bundle between the AES round engine and its neighbours.
// The master side issues requests and takes results; the slave side is the core.
interface aes_iter_core_if #(
    parameter int MAX_NK = 8
);
    localparam int KS_W = 128 * (MAX_NK + 7);

    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    logic [7:0]      Nk;
    logic [127:0]    in_data;
    logic [KS_W-1:0] keySchedule;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    out_data;
    logic            out_err;
    logic            busy;

    modport master (
        output in_valid, in_mode, Nk, in_data, keySchedule, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );

    modport slave (
        input  in_valid, in_mode, Nk, in_data, keySchedule, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES engine: one round per clock, encrypt or decrypt per request,
// AES-128/192/256 selected by Nk, round keys taken from an externally held
// expanded key schedule. S-boxes are computed from the GF(2^8) inverse.
package aes_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] b, r;
        b = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            b = gmul(b, b);
            r = gmul(r, b);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    // byte n sits at row n%4, column n/4; ShiftRows pulls row r from column c+r
    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            src = 4 * (((n / 4) + (n % 4)) % 4) + (n % 4);
            o[127-8*n -: 8] = sbox(s[127-8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] invShiftSub(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            src = 4 * (((n / 4) + 4 - (n % 4)) % 4) + (n % 4);
            o[127-8*n -: 8] = invSbox(s[127-8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mixCols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                       ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] invMixCols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                                       ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
        end
        return o;
    endfunction
endpackage

// Key whitening: plain XOR of the block with a round key.
module AddRoundKey (
    input  logic [127:0] i_data,
    input  logic [127:0] i_key,
    output logic [127:0] o_data
);
    assign o_data = i_data ^ i_key;
endmodule

// Forward round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module Round (
    input  logic [127:0] i_data,
    input  logic [127:0] i_key,
    input  logic         i_mixEn,
    output logic [127:0] o_data
);
    import aes_pkg::*;
    logic [127:0] w_sr, w_mix;
    assign w_sr  = subShift(i_data);
    assign w_mix = i_mixEn ? mixCols(w_sr) : w_sr;
    AddRoundKey u_ark (.i_data(w_mix), .i_key(i_key), .o_data(o_data));
endmodule

// Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module Inverse_Round (
    input  logic [127:0] i_data,
    input  logic [127:0] i_key,
    input  logic         i_mixEn,
    output logic [127:0] o_data
);
    import aes_pkg::*;
    logic [127:0] w_sr, w_ark;
    assign w_sr = invShiftSub(i_data);
    AddRoundKey u_ark (.i_data(w_sr), .i_key(i_key), .o_data(w_ark));
    assign o_data = i_mixEn ? invMixCols(w_ark) : w_ark;
endmodule

module aes_iter_core #(
    parameter int MAX_NK = 8,
    parameter bit ENC_EN = 1'b1,
    parameter bit DEC_EN = 1'b1
) (
    input logic           clk,
    input logic           reset,
    aes_iter_core_if.slave bus
);
    localparam int KS_W = 128 * (MAX_NK + 7);
    localparam int NRK  = MAX_NK + 7;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       r_state, w_nextState;
    logic         r_mode, r_err;
    logic [3:0]   r_nr, r_cnt;
    logic [127:0] r_block;

    logic         w_accept, w_illegal, w_nkOk, w_modeOk, w_mixEn;
    logic [3:0]   w_nrIn, w_inIdx, w_rndIdx;
    logic [127:0] w_inKey, w_rndKey, w_whiten, w_fwdOut, w_invOut;

    assign bus.in_ready = reset & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
    assign w_accept     = bus.in_valid & bus.in_ready;

    assign w_nrIn   = (bus.Nk == 8'd4) ? 4'd10 :
                      (bus.Nk == 8'd6) ? 4'd12 :
                      (bus.Nk == 8'd8) ? 4'd14 : 4'd0;
    assign w_nkOk   = (w_nrIn != 4'd0) && (bus.Nk <= 8'(MAX_NK));
    assign w_modeOk = bus.in_mode ? DEC_EN : ENC_EN;
    assign w_illegal = !(w_nkOk && w_modeOk);

    assign w_inIdx  = bus.in_mode ? w_nrIn : 4'd0;
    assign w_rndIdx = r_mode ? (r_nr - r_cnt) : r_cnt;
    assign w_mixEn  = (r_cnt < r_nr);

    // Pick whitening and round keys; indices beyond the built schedule yield zero
    always_comb begin
        w_inKey  = '0;
        w_rndKey = '0;
        for (int i = 0; i < NRK; i++) begin
            if (w_inIdx == 4'(i))  w_inKey  = bus.keySchedule[KS_W-1-128*i -: 128];
            if (w_rndIdx == 4'(i)) w_rndKey = bus.keySchedule[KS_W-1-128*i -: 128];
        end
    end

    AddRoundKey u_whiten (.i_data(bus.in_data), .i_key(w_inKey), .o_data(w_whiten));

    if (ENC_EN) begin : g_enc
        Round u_round (.i_data(r_block), .i_key(w_rndKey), .i_mixEn(w_mixEn), .o_data(w_fwdOut));
    end else begin : g_noEnc
        assign w_fwdOut = '0;
    end

    if (DEC_EN) begin : g_dec
        Inverse_Round u_invRound (.i_data(r_block), .i_key(w_rndKey), .i_mixEn(w_mixEn),
                                  .o_data(w_invOut));
    end else begin : g_noDec
        assign w_invOut = '0;
    end

    // Control state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Next state: illegal requests pass through ROUND for one cycle without computing
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = ROUND;
            ROUND:   if (r_err || (r_cnt >= r_nr)) w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = w_accept ? ROUND : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: load on accept, then one round per cycle with a saturating counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= 1'b0;
            r_err   <= 1'b0;
            r_nr    <= 4'd0;
            r_cnt   <= 4'd0;
            r_block <= '0;
        end else if (w_accept) begin
            r_mode  <= bus.in_mode;
            r_err   <= w_illegal;
            r_nr    <= w_nrIn;
            r_cnt   <= 4'd1;
            r_block <= w_illegal ? 128'd0 : w_whiten;
        end else if ((r_state == ROUND) && !r_err) begin
            r_block <= r_mode ? w_invOut : w_fwdOut;
            r_cnt   <= (r_cnt == 4'hf) ? r_cnt : r_cnt + 4'd1;
        end
    end

    assign bus.out_valid = (r_state == DONE);
    assign bus.out_data  = (r_state == DONE) ? r_block : 128'd0;
    assign bus.out_err   = (r_state == DONE) & r_err;
    assign bus.busy      = (r_state == ROUND) | (r_state == DONE);
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Parametrised iterative AES engine, one round per clock, with encrypt and decrypt modes selected per request. Supports AES-128/192/256 via Nk and uses a valid/ready handshake on input and output with output back-pressure. Sits between the key-expansion block, which supplies the full expanded key schedule, and the block-mode and datapath logic. Instantiates the team's AddRoundKey, Round (forward) and Inverse_Round blocks.

Parameters:
MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8). KS_W = 128*(MAX_NK+7).
ENC_EN, 1, 1 = encrypt path built. 0 = encrypt requests flagged as errors.
DEC_EN, 1, 1 = decrypt path built. 0 = decrypt requests flagged as errors.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  core can accept a request.
in_mode  in  1  0 = encrypt, 1 = decrypt.
Nk  in  8  key words: 4, 6 or 8.
in_data  in  128  plaintext or ciphertext.
keySchedule  in  KS_W  round keys. RK(i) = keySchedule[KS_W-1-128*i -: 128], where RK(0) is the encryption-order first key.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  128  result block.
out_err  out  1  request was illegal. Qualified by out_valid.
busy  out  1  a request is in flight (ROUND or DONE).

Behaviour:
- Reset (reset=0, async): state=IDLE, out_valid=0, out_err=0, out_data=0, busy=0, round counter=0, in_ready=0 while asserted. An in-flight request is discarded with no output.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- A transfer occurs on an edge with in_valid & in_ready.
- Nr = 10/12/14 for Nk = 4/6/8.
- Illegal request: Nk not in {4,6,8}, Nk > MAX_NK, or a disabled mode.
- Accept, legal request (edge T):
  - Latch mode and Nr; counter <= 1.
  - Encrypt: state_reg <= in_data ^ RK(0).
  - Decrypt: state_reg <= in_data ^ RK(Nr).
  - Go to ROUND.
- ROUND (edges T+1..T+Nr): apply one round per edge.
  - Encrypt round r uses RK(r). Decrypt round r uses RK(Nr-r).
  - MixColumns / InvMixColumns is enabled for r < Nr and disabled for r = Nr.
  - Counter increments each edge. At edge T+Nr go to DONE and set out_valid=1.
  - Latency: out_valid is high in the cycle after edge T+Nr. That is 11/13/15 cycles after the accept cycle.
- Illegal request: accepted, go directly to DONE at edge T+1 with out_err=1 and out_data=0. No round is executed.
- DONE:
  - out_data and out_err are held stable until out_valid & out_ready.
  - On out_ready with no new accept: go to IDLE and set out_valid=0.
  - On out_ready with a simultaneous accept: load the new request and go to ROUND (or DONE if illegal). out_valid drops for at least Nr cycles. Zero bubble cycles on the input side.
- in_data, in_mode and Nk are sampled only at accept. keySchedule must be held stable from accept until out_valid. It is not latched.
- in_valid while busy and not in_ready is ignored. The upstream must hold the request per the handshake.
- out_data is driven from state_reg only in DONE (0 otherwise). No X propagates to outputs.
- Key indices never exceed 14. The counter is 4 bits and saturates, with no wrap.

Test Plan:
- AES-128 encrypt, FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_err=0, out_valid 11 cycles after accept.
- AES-128 decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a, same key -> 00112233445566778899aabbccddeeff after 11 cycles.
- AES-192 (key 00..17) encrypt -> dda97ca4864cdfe06eaf70a0ec0d7191. AES-256 (key 00..1f) decrypt of 8ea2b7ca516745bfeafc49904b496089 -> 00112233..eeff, latency 15. Also repeat AES-256 encrypt/decrypt with MAX_NK=4 -> out_err=1, out_data=0, latency 2.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new request accepted the same edge, next result correct.
- Illegal Nk=5 -> out_err=1, out_data=0, no round executed. The next legal request completes correctly.
- Assert reset mid-ROUND (cycle 5 of AES-128) -> outputs 0, state IDLE immediately. After release, a fresh request completes with correct ciphertext.
